// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage driving a valid/ready data bus and the MEM/WB register.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses issue no request and pulse err_o.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        RegWrite_i,
    input  logic [1:0]  WriteSrc_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] regOp2_i,
    input  logic [31:0] pcPlus4_i,
    input  logic [31:0] ImmOp_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic        RegWrite_o,
    output logic [1:0]  WriteSrc_o,
    output logic [31:0] ALUout_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] pcPlus4_o,
    output logic [31:0] ImmOp_o,
    output logic [4:0]  rd_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       a;
    logic             access;
    logic             misalign;
    logic             req;
    logic             done;
    logic             abort;
    logic             timeout_hit;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;

    assign a      = ALUout_i[1:0];
    assign access = valid_i & (MemWrite_i | (WriteSrc_i == 2'b01));

`ifdef MISALIGN_TRAP_EN
    assign misalign = access & (((funct3_i[1:0] == 2'b01) & a[0]) |
                                ((funct3_i[1:0] == 2'b10) & (a != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TMO);

    // Ready only counts while a request is on the bus; the timeout cycle drops req first.
    always_comb begin
        req   = 1'b0;
        done  = 1'b1;
        abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access & ~misalign) begin
                    req  = 1'b1;
                    done = dmem_ready_i;
                end
                abort = misalign;
            end
            ST_WAIT: begin
                if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    req  = 1'b1;
                    done = dmem_ready_i;
                end
            end
            default: ;
        endcase
    end

    assign dmem_req_o   = rst_ni & req;
    assign stall_o      = rst_ni & ~done;
    assign err_o        = rst_ni & abort;
    assign dmem_we_o    = MemWrite_i;
    assign dmem_addr_o  = {ALUout_i[31:2], 2'b00};

    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                dmem_be_o    = 4'b0001 << a;
                dmem_wdata_o = {4{regOp2_i[7:0]}};
            end
            2'b01: begin
                dmem_be_o    = a[1] ? 4'b1100 : 4'b0011;
                dmem_wdata_o = {2{regOp2_i[15:0]}};
            end
            default: begin
                dmem_be_o    = 4'b1111;
                dmem_wdata_o = regOp2_i;
            end
        endcase
    end

    assign byte_sel = 8'(dmem_rdata_i >> {a, 3'b000});
    assign half_sel = a[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    always_comb begin
        case (funct3_i)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!done) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (done) state <= ST_IDLE;
                    else      wait_cnt <= wait_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB register: a stalled cycle writes a bubble and leaves the data fields alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            RegWrite_o <= 1'b0;
            WriteSrc_o <= '0;
            ALUout_o   <= '0;
            ReadData_o <= '0;
            pcPlus4_o  <= '0;
            ImmOp_o    <= '0;
            rd_o       <= '0;
        end else if (!done) begin
            RegWrite_o <= 1'b0;
        end else begin
            RegWrite_o <= valid_i & RegWrite_i & ~abort;
            WriteSrc_o <= WriteSrc_i;
            ALUout_o   <= ALUout_i;
            ReadData_o <= load_data;
            pcPlus4_o  <= pcPlus4_i;
            ImmOp_o    <= ImmOp_i;
            rd_o       <= rd_i;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized bench for mem_stage against a transaction-level memory model.
module tb_mem_stage;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i, RegWrite_i, MemWrite_i, dmem_ready_i;
    logic [1:0]  WriteSrc_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALUout_i, regOp2_i, pcPlus4_i, ImmOp_i, dmem_rdata_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o, dmem_we_o, stall_o, err_o, RegWrite_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, ALUout_o, ReadData_o, pcPlus4_o, ImmOp_o;
    logic [3:0]  dmem_be_o;
    logic [1:0]  WriteSrc_o;
    logic [4:0]  rd_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]  m_rd;
    logic [31:0] m_alu;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
        .WriteSrc_i(WriteSrc_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i),
        .ALUout_i(ALUout_i), .regOp2_i(regOp2_i), .pcPlus4_i(pcPlus4_i), .ImmOp_i(ImmOp_i),
        .rd_i(rd_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .err_o(err_o), .RegWrite_o(RegWrite_o),
        .WriteSrc_o(WriteSrc_o), .ALUout_o(ALUout_o), .ReadData_o(ReadData_o),
        .pcPlus4_o(pcPlus4_o), .ImmOp_o(ImmOp_o), .rd_o(rd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called right after a falling edge; returns at the falling edge after the instruction retires.
    task automatic run_instr(input logic v, input logic rw, input logic [1:0] ws, input logic mw,
                             input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [31:0] pc4, input logic [31:0] imm, input logic [4:0] rd,
                             input int w, input logic [31:0] rdata);
        logic        acc, mis, ld, done, abrt, exp_req;
        logic [1:0]  a;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld, wrd;
        logic [7:0]  b;
        logic [15:0] h;
        a   = addr[1:0];
        acc = v && (mw || ws == 2'b01);
        ld  = acc && !mw;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = acc && ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00));
`endif
        case (f3[1:0])
            2'b00:   begin ebe = 4'(1 << a);                    ewd = {4{rs2[7:0]}};  end
            2'b01:   begin ebe = (a >= 2) ? 4'b1100 : 4'b0011; ewd = {2{rs2[15:0]}}; end
            default: begin ebe = 4'b1111;                       ewd = rs2;            end
        endcase
        wrd = rdata;
        b   = wrd[8*a +: 8];
        h   = (a >= 2) ? wrd[31:16] : wrd[15:0];
        case (f3)
            3'b000:  eld = 32'($signed(b));
            3'b001:  eld = 32'($signed(h));
            3'b100:  eld = {24'h0, b};
            3'b101:  eld = {16'h0, h};
            default: eld = wrd;
        endcase
        valid_i = v; RegWrite_i = rw; WriteSrc_i = ws; MemWrite_i = mw; funct3_i = f3;
        ALUout_i = addr; regOp2_i = rs2; pcPlus4_i = pc4; ImmOp_i = imm; rd_i = rd;
        for (int k = 0; k <= TMO + 1; k++) begin
            abrt = 1'b0;
            if (!acc || mis) begin
                dmem_ready_i = 1'($urandom);
                done = 1'b1;
                abrt = mis;
            end else if (k == TMO + 1) begin
                dmem_ready_i = 1'($urandom);
                done = 1'b1;
                abrt = 1'b1;
            end else begin
                done = (k == w);
                dmem_ready_i = done;
            end
            dmem_rdata_i = (acc && k == w) ? rdata : $urandom;
            exp_req = acc && !mis && (k != TMO + 1);
            #1;
            check("req", 32'(dmem_req_o), 32'(exp_req));
            if (exp_req) begin
                check("we", 32'(dmem_we_o), 32'(mw));
                check("addr", dmem_addr_o, {addr[31:2], 2'b00});
                if (mw) begin
                    check("be", 32'(dmem_be_o), 32'(ebe));
                    check("wdata", dmem_wdata_o, ewd);
                end
            end
            check("stall", 32'(stall_o), 32'(!done));
            check("err", 32'(err_o), 32'(abrt));
            @(posedge clk_i);
            #1;
            if (!done) begin
                check("bubble_rw", 32'(RegWrite_o), 32'h0);
                check("hold_rd", 32'(rd_o), 32'(m_rd));
                check("hold_alu", ALUout_o, m_alu);
            end else begin
                m_rd  = rd;
                m_alu = addr;
                check("wb_rw", 32'(RegWrite_o), 32'(v && rw && !abrt));
                check("wb_ws", 32'(WriteSrc_o), 32'(ws));
                check("wb_alu", ALUout_o, addr);
                check("wb_pc4", pcPlus4_o, pc4);
                check("wb_imm", ImmOp_o, imm);
                check("wb_rd", 32'(rd_o), 32'(rd));
                if (ld && !abrt) check("wb_rdata", ReadData_o, eld);
            end
            @(negedge clk_i);
            if (done) break;
        end
        dmem_ready_i = 1'b0;
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        int kind;
        logic       v, rw, mw;
        logic [1:0] ws;
        logic [2:0] f3;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3 = '{3'b000, 3'b001, 3'b010};
        valid_i = 1'b1; RegWrite_i = 1'b1; WriteSrc_i = 2'b01; MemWrite_i = 1'b0;
        funct3_i = 3'b010; ALUout_i = 32'h40; regOp2_i = '0; pcPlus4_i = '0; ImmOp_i = '0;
        rd_i = 5'd3; dmem_ready_i = 1'b0; dmem_rdata_i = '0;
        m_rd = '0; m_alu = '0;

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_req", 32'(dmem_req_o), 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_rw", 32'(RegWrite_o), 32'h0);
        check("rst_rd", 32'(rd_o), 32'h0);
        check("rst_rdata", ReadData_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_instr(1, 0, 2'b00, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h8, 32'h0, 5'd0, 0, 32'h0);
        run_instr(1, 1, 2'b01, 0, 3'b000, 32'h103, 32'h0, 32'hC, 32'h3, 5'd5, 3, 32'h80FF1234);
        check("lb_value", ReadData_o, 32'hFFFFFF80);
        run_instr(1, 0, 2'b00, 1, 3'b000, 32'h102, 32'h000000AB, 32'h10, 32'h2, 5'd0, 1, 32'h0);
        run_instr(1, 1, 2'b01, 0, 3'b101, 32'h102, 32'h0, 32'h14, 32'h2, 5'd6, 2, 32'hBEEF0000);
        check("lhu_value", ReadData_o, 32'h0000BEEF);
        run_instr(1, 1, 2'b01, 0, 3'b010, 32'h200, 32'h0, 32'h18, 32'h0, 5'd7, 100, 32'h0);
        run_instr(1, 1, 2'b01, 0, 3'b010, 32'h102, 32'h0, 32'h1C, 32'h2, 5'd8, 0, 32'h11223344);

        // Reset dropped in the middle of a wait-stated load.
        valid_i = 1'b1; RegWrite_i = 1'b1; WriteSrc_i = 2'b01; MemWrite_i = 1'b0;
        funct3_i = 3'b010; ALUout_i = 32'h300; rd_i = 5'd9; dmem_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_req", 32'(dmem_req_o), 32'h0);
        check("arst_stall", 32'(stall_o), 32'h0);
        check("arst_err", 32'(err_o), 32'h0);
        check("arst_rw", 32'(RegWrite_o), 32'h0);
        check("arst_rd", 32'(rd_o), 32'h0);
        check("arst_alu", ALUout_o, 32'h0);
        check("arst_pc4", pcPlus4_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_rd = '0; m_alu = '0;
        run_instr(1, 1, 2'b01, 0, 3'b001, 32'h302, 32'h0, 32'h20, 32'h0, 5'd10, 1, 32'h8001_7FFF);

        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 3);
            v = 1'b1; rw = 1'($urandom); mw = 1'b0; ws = 2'($urandom); f3 = 3'($urandom);
            case (kind)
                0: begin v = 1'b0; mw = 1'($urandom); end
                1: begin ws = (ws == 2'b01) ? 2'b00 : ws; end
                2: begin ws = 2'b01; f3 = ld_f3[$urandom_range(0, 4)]; end
                default: begin mw = 1'b1; f3 = st_f3[$urandom_range(0, 2)]; end
            endcase
            run_instr(v, rw, ws, mw, f3, $urandom, $urandom, $urandom, $urandom, 5'($urandom),
                      $urandom_range(0, 6), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
